// File: rtl/nubus_pkg.sv
// Shared NuBus slave definitions: FSM states, acknowledge status codes and
// the default memory wait limit.
package nubus_pkg;

   typedef enum logic [1:0] {StIdle, StWdat, StMem, StAck} state_e;

   // Status encodings as {tm1n, tm0n} driven during the acknowledge cycle.
   localparam logic [1:0] ST_COMPLETE = 2'b11;
   localparam logic [1:0] ST_ERROR    = 2'b10;
   localparam logic [1:0] ST_RETRY    = 2'b00;

   localparam int unsigned WAIT_LIMIT_DEFAULT = 255;

endpackage

// File: rtl/nubus_slv_tmdecode.sv
// Combinational NuBus TM/AD[1:0] transfer-type decode into byte lanes,
// a write flag and a reserved-code error.
module nubus_slv_tmdecode (
   input  logic       tm1n,
   input  logic       tm0n,
   input  logic [1:0] ad_lo,
   output logic [3:0] lanes,
   output logic       write,
   output logic       dec_err
);

   always_comb begin
      lanes   = 4'b0000;
      dec_err = 1'b0;
      write   = ~tm1n;
      if (!tm0n) begin
         lanes = 4'b0001 << ad_lo;
      end else begin
         unique case (ad_lo)
            2'b00:   lanes = 4'b1111;
            2'b01:   lanes = 4'b0011;
            2'b11:   lanes = 4'b1100;
            default: dec_err = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/nubus_slvbus.sv
// NuBus slave transaction engine: slot decode, one local memory access, ACK cycle.
// Define NUBUS_SUPERSLOT_EN to also respond in super-slot space (slot IDs 9..E).
module nubus_slvbus
   import nubus_pkg::*;
#(
   parameter int unsigned WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
   input  logic        nub_clkn,
   input  logic        nub_resetn,
   input  logic        nub_startn,
   input  logic        nub_ackn_i,
   input  logic [31:0] nub_ad_i,
   input  logic        nub_tm1n_i,
   input  logic        nub_tm0n_i,
   input  logic [3:0]  slot_id,
   output logic [31:0] nub_ad_o,
   output logic        nub_ad_oe,
   output logic        nub_ackn_o,
   output logic        nub_tm1n_o,
   output logic        nub_tm0n_o,
   output logic        nub_ackoe,
   output logic        mem_valid,
   output logic [3:0]  mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   input  logic        mem_error
);

   localparam logic [7:0] LimitM1 = 8'(WAIT_LIMIT - 1);

   state_e     state_q;
   logic [7:0] cnt_q;
   logic [3:0] dec_lanes;
   logic       dec_write;
   logic       dec_err;
   logic       match;
   logic       addr_cycle;

   nubus_slv_tmdecode u_tmdecode (
      .tm1n    (nub_tm1n_i),
      .tm0n    (nub_tm0n_i),
      .ad_lo   (nub_ad_i[1:0]),
      .lanes   (dec_lanes),
      .write   (dec_write),
      .dec_err (dec_err)
   );

   always_comb begin
      match = (nub_ad_i[31:24] == {4'hF, slot_id});
`ifdef NUBUS_SUPERSLOT_EN
      if (slot_id >= 4'h9 && slot_id <= 4'hE && nub_ad_i[31:28] == slot_id) begin
         match = 1'b1;
      end
`endif
   end

   // ACK low alongside START marks an attention cycle, never an access.
   assign addr_cycle = !nub_startn && nub_ackn_i && match;

   always_ff @(posedge nub_clkn or negedge nub_resetn) begin
      if (!nub_resetn) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         mem_valid  <= 1'b0;
         mem_write  <= 4'b0000;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         nub_ad_o   <= '0;
         nub_ad_oe  <= 1'b0;
         nub_ackn_o <= 1'b1;
         nub_tm1n_o <= 1'b1;
         nub_tm0n_o <= 1'b1;
         nub_ackoe  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (addr_cycle) begin
                  mem_addr  <= {nub_ad_i[31:2], 2'b00};
                  mem_write <= dec_write ? dec_lanes : 4'b0000;
                  cnt_q     <= '0;
                  if (dec_err) begin
                     state_q                  <= StAck;
                     nub_ackn_o               <= 1'b0;
                     nub_ackoe                <= 1'b1;
                     {nub_tm1n_o, nub_tm0n_o} <= ST_ERROR;
                  end else if (dec_write) begin
                     state_q <= StWdat;
                  end else begin
                     state_q   <= StMem;
                     mem_valid <= 1'b1;
                  end
               end
            end
            StWdat: begin
               mem_wdata <= nub_ad_i;
               mem_valid <= 1'b1;
               state_q   <= StMem;
            end
            StMem: begin
               // Ready wins over the timeout when both land on the same edge.
               if (mem_ready) begin
                  mem_valid                <= 1'b0;
                  nub_ad_o                 <= mem_rdata;
                  nub_ad_oe                <= !mem_error && (mem_write == 4'b0000);
                  nub_ackn_o               <= 1'b0;
                  nub_ackoe                <= 1'b1;
                  {nub_tm1n_o, nub_tm0n_o} <= mem_error ? ST_ERROR : ST_COMPLETE;
                  state_q                  <= StAck;
               end else if (cnt_q == LimitM1) begin
                  mem_valid                <= 1'b0;
                  nub_ackn_o               <= 1'b0;
                  nub_ackoe                <= 1'b1;
                  {nub_tm1n_o, nub_tm0n_o} <= ST_RETRY;
                  state_q                  <= StAck;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            StAck: begin
               nub_ackn_o               <= 1'b1;
               nub_ackoe                <= 1'b0;
               nub_ad_oe                <= 1'b0;
               {nub_tm1n_o, nub_tm0n_o} <= ST_COMPLETE;
               state_q                  <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_nubus_slvbus.sv
// Scoreboard bench for nubus_slvbus: directed NuBus accesses queue expected
// memory requests and ACK cycles; monitors pop and compare as the DUT presents them.
module tb_nubus_slvbus;

   logic        nub_clkn;
   logic        nub_resetn;
   logic        nub_startn;
   logic        nub_ackn_i;
   logic [31:0] nub_ad_i;
   logic        nub_tm1n_i;
   logic        nub_tm0n_i;
   logic [3:0]  slot_id;
   logic [31:0] nub_ad_o;
   logic        nub_ad_oe;
   logic        nub_ackn_o;
   logic        nub_tm1n_o;
   logic        nub_tm0n_o;
   logic        nub_ackoe;
   logic        mem_valid;
   logic [3:0]  mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        mem_error;

   nubus_slvbus #(.WAIT_LIMIT(4)) dut (
      .nub_clkn   (nub_clkn),
      .nub_resetn (nub_resetn),
      .nub_startn (nub_startn),
      .nub_ackn_i (nub_ackn_i),
      .nub_ad_i   (nub_ad_i),
      .nub_tm1n_i (nub_tm1n_i),
      .nub_tm0n_i (nub_tm0n_i),
      .slot_id    (slot_id),
      .nub_ad_o   (nub_ad_o),
      .nub_ad_oe  (nub_ad_oe),
      .nub_ackn_o (nub_ackn_o),
      .nub_tm1n_o (nub_tm1n_o),
      .nub_tm0n_o (nub_tm0n_o),
      .nub_ackoe  (nub_ackoe),
      .mem_valid  (mem_valid),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .mem_error  (mem_error)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  wr;
      logic [31:0] wdata;
      logic        chk_wd;
   } req_t;

   typedef struct packed {
      logic [1:0]  st;
      logic        oe;
      logic [31:0] data;
   } ack_t;

   req_t exp_req[$];
   ack_t exp_ack[$];
   req_t cur_req;
   ack_t cur_ack;
   logic [67:0] held;
   logic prev_valid = 1'b0;
   logic prev_ack = 1'b0;
   int checks = 0;
   int errors = 0;
   int cyc = 0;

   initial nub_clkn = 1'b0;
   always #5 nub_clkn = ~nub_clkn;
   always @(posedge nub_clkn) cyc++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Memory-request monitor: compare on first valid cycle, then check hold stability.
   always @(negedge nub_clkn) begin
      if (mem_valid && !prev_valid) begin
         chk("req_expected", 128'(exp_req.size() > 0), 128'(1));
         if (exp_req.size() > 0) begin
            cur_req = exp_req.pop_front();
            chk("req_addr", 128'(mem_addr), 128'(cur_req.addr));
            chk("req_write", 128'(mem_write), 128'(cur_req.wr));
            if (cur_req.chk_wd) chk("req_wdata", 128'(mem_wdata), 128'(cur_req.wdata));
         end
         held = {mem_addr, mem_write, mem_wdata};
      end else if (mem_valid && prev_valid) begin
         chk("req_hold", 128'({mem_addr, mem_write, mem_wdata}), 128'(held));
      end
      if (!nub_ackn_o) begin
         chk("ack_single_cycle", 128'(prev_ack), 128'(0));
         chk("ack_expected", 128'(exp_ack.size() > 0), 128'(1));
         if (exp_ack.size() > 0) begin
            cur_ack = exp_ack.pop_front();
            chk("ack_oe", 128'(nub_ackoe), 128'(1));
            chk("ack_tm", 128'({nub_tm1n_o, nub_tm0n_o}), 128'(cur_ack.st));
            chk("ack_ad_oe", 128'(nub_ad_oe), 128'(cur_ack.oe));
            if (cur_ack.oe) chk("ack_data", 128'(nub_ad_o), 128'(cur_ack.data));
         end
      end else begin
         chk("drivers_released", 128'({nub_ackoe, nub_ad_oe}), 128'(0));
      end
      prev_valid = mem_valid;
      prev_ack   = !nub_ackn_o;
   end

   task automatic wait_ack(input int c0, input int lat);
      int k = 0;
      while (nub_ackn_o && k < 20) begin
         @(negedge nub_clkn);
         k++;
      end
      chk("ack_seen", 128'(!nub_ackn_o), 128'(1));
      chk("ack_latency", 128'(cyc - c0), 128'(lat));
      @(negedge nub_clkn);
   endtask

   task automatic start_cycle(input logic [31:0] ad, input logic tm1n, input logic tm0n,
                              input logic ackn);
      nub_startn = 1'b0;
      nub_ackn_i = ackn;
      nub_ad_i   = ad;
      nub_tm1n_i = tm1n;
      nub_tm0n_i = tm0n;
   endtask

   task automatic txn(input logic [31:0] ad, input logic tm1n, input logic tm0n,
                      input logic [31:0] data, input int wait_cyc, input logic err,
                      input logic exp_mem, input logic [3:0] exp_wr,
                      input logic [1:0] exp_st, input logic exp_oe);
      int k;
      int c0;
      int lat;
      req_t r;
      ack_t a;
      if (exp_mem) begin
         r.addr   = {ad[31:2], 2'b00};
         r.wr     = exp_wr;
         r.wdata  = data;
         r.chk_wd = (exp_wr != 4'b0000);
         exp_req.push_back(r);
      end
      a.st   = exp_st;
      a.oe   = exp_oe;
      a.data = data;
      exp_ack.push_back(a);
      lat = exp_mem ? 2 + ((exp_wr != 4'b0000) ? 1 : 0) + wait_cyc : 1;
      start_cycle(ad, tm1n, tm0n, 1'b1);
      c0 = cyc;
      @(negedge nub_clkn);
      nub_startn = 1'b1;
      nub_ad_i   = data;
      nub_tm1n_i = 1'b1;
      nub_tm0n_i = 1'b1;
      if (exp_mem) begin
         k = 0;
         while (!mem_valid && k < 8) begin
            @(negedge nub_clkn);
            k++;
         end
         chk("mem_valid_seen", 128'(mem_valid), 128'(1));
         // Matching STARTs during the wait must be ignored.
         for (int i = 0; i < wait_cyc; i++) begin
            nub_startn = 1'b0;
            nub_ad_i   = 32'hF900_0000;
            @(negedge nub_clkn);
         end
         nub_startn = 1'b1;
         mem_ready  = 1'b1;
         mem_rdata  = data;
         mem_error  = err;
         @(negedge nub_clkn);
         mem_ready = 1'b0;
         mem_error = 1'b0;
      end
      wait_ack(c0, lat);
   endtask

   task automatic ignored_start(input string name, input logic [31:0] ad, input logic ackn);
      logic ok = 1'b1;
      start_cycle(ad, 1'b1, 1'b1, ackn);
      @(negedge nub_clkn);
      nub_startn = 1'b1;
      nub_ackn_i = 1'b1;
      repeat (4) begin
         @(negedge nub_clkn);
         if (mem_valid || !nub_ackn_o) ok = 1'b0;
      end
      chk(name, 128'(ok), 128'(1));
   endtask

   initial begin
      int k;
      int c0;
      req_t r;
      ack_t a;
      nub_resetn = 1'b0;
      nub_startn = 1'b1;
      nub_ackn_i = 1'b1;
      nub_ad_i   = '0;
      nub_tm1n_i = 1'b1;
      nub_tm0n_i = 1'b1;
      slot_id    = 4'h9;
      mem_rdata  = '0;
      mem_ready  = 1'b0;
      mem_error  = 1'b0;
      #12;
      chk("reset_values",
          128'({mem_valid, mem_write, mem_addr, mem_wdata, nub_ad_o, nub_ad_oe,
                nub_ackn_o, nub_tm1n_o, nub_tm0n_o, nub_ackoe}),
          128'({1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}));
      @(negedge nub_clkn);
      nub_resetn = 1'b1;
      @(negedge nub_clkn);

      // ad, tm1n, tm0n, data, wait, err, mem, lanes, status, ad_oe
      txn(32'hF900_0100, 1, 1, 32'hDEAD_BEEF, 0, 0, 1, 4'b0000, 2'b11, 1);
      txn(32'hF900_0010, 0, 0, 32'h0000_0011, 0, 0, 1, 4'b0001, 2'b11, 0);
      txn(32'hF900_0011, 0, 0, 32'h0000_2200, 0, 0, 1, 4'b0010, 2'b11, 0);
      txn(32'hF900_0012, 0, 0, 32'h0000_00AA, 0, 0, 1, 4'b0100, 2'b11, 0);
      txn(32'hF900_0013, 0, 0, 32'h4400_0000, 0, 0, 1, 4'b1000, 2'b11, 0);
      txn(32'hF900_0020, 0, 1, 32'hCAFE_F00D, 0, 0, 1, 4'b1111, 2'b11, 0);
      txn(32'hF900_0021, 0, 1, 32'h0000_5566, 0, 0, 1, 4'b0011, 2'b11, 0);
      txn(32'hF900_0023, 0, 1, 32'h7788_0000, 0, 0, 1, 4'b1100, 2'b11, 0);
      txn(32'hF900_0201, 1, 1, 32'h1234_5678, 0, 0, 1, 4'b0000, 2'b11, 1);
      txn(32'hF900_0303, 1, 0, 32'h0BAD_CAFE, 0, 0, 1, 4'b0000, 2'b11, 1);
      txn(32'hF900_0400, 1, 1, 32'h5A5A_5A5A, 0, 1, 1, 4'b0000, 2'b10, 0);
      txn(32'hF900_0404, 0, 1, 32'h0101_0101, 0, 1, 1, 4'b1111, 2'b10, 0);
      txn(32'hF900_0002, 0, 1, 32'h0000_0000, 0, 0, 0, 4'b0000, 2'b10, 0);
      txn(32'hF900_0500, 1, 1, 32'hA5A5_0002, 2, 0, 1, 4'b0000, 2'b11, 1);
      txn(32'hF900_0600, 1, 1, 32'h0000_0603, 3, 0, 1, 4'b0000, 2'b11, 1);

      // Timeout: ready never arrives, valid lasts exactly WAIT_LIMIT cycles.
      r = '{addr: 32'hF900_0700, wr: 4'b0000, wdata: 32'h0, chk_wd: 1'b0};
      exp_req.push_back(r);
      a = '{st: 2'b00, oe: 1'b0, data: 32'h0};
      exp_ack.push_back(a);
      start_cycle(32'hF900_0700, 1'b1, 1'b1, 1'b1);
      c0 = cyc;
      @(negedge nub_clkn);
      nub_startn = 1'b1;
      k = 0;
      while (mem_valid && k < 20) begin
         k++;
         @(negedge nub_clkn);
      end
      chk("timeout_valid_cycles", 128'(k), 128'(4));
      wait_ack(c0, 5);

      ignored_start("ignore_other_slot", 32'hFA00_0000, 1'b1);
      ignored_start("ignore_attention", 32'hF900_0000, 1'b0);
`ifdef NUBUS_SUPERSLOT_EN
      txn(32'h9000_0000, 1, 1, 32'h0000_9999, 0, 0, 1, 4'b0000, 2'b11, 1);
`else
      ignored_start("ignore_superslot", 32'h9000_0000, 1'b1);
`endif

      // Reset while the request is outstanding.
      r = '{addr: 32'hF900_0800, wr: 4'b0000, wdata: 32'h0, chk_wd: 1'b0};
      exp_req.push_back(r);
      start_cycle(32'hF900_0800, 1'b1, 1'b1, 1'b1);
      @(negedge nub_clkn);
      nub_startn = 1'b1;
      chk("reset_txn_valid", 128'(mem_valid), 128'(1));
      #2 nub_resetn = 1'b0;
      #1;
      chk("reset_async", 128'({mem_valid, nub_ackoe, nub_ackn_o, nub_ad_oe}), 128'(4'b0010));
      @(negedge nub_clkn);
      nub_resetn = 1'b1;
      ignored_start("idle_after_reset", 32'hFA00_0000, 1'b1);
      txn(32'hF900_0900, 0, 0, 32'h0000_0077, 0, 0, 1, 4'b0001, 2'b11, 0);
      txn(32'hF900_0A00, 1, 1, 32'hFEED_FACE, 1, 0, 1, 4'b0000, 2'b11, 1);

      chk("queues_drained", 128'(exp_req.size() + exp_ack.size()), 128'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
